// File: rtl/sound_sequencer_if.sv
// Game-state to sound-sequencer link: sound request/selector in, speaker drive and status out.
interface sound_sequencer_if;
  logic [1:0] soundselector;
  logic       playsound;
  logic       speaker;
  logic       busy;
  logic       done;
  logic [1:0] note_idx;

  modport master (
    output soundselector, playsound,
    input  speaker, busy, done, note_idx
  );

  modport slave (
    input  soundselector, playsound,
    output speaker, busy, done, note_idx
  );
endinterface

// File: rtl/sound_sequencer.sv
// Plays a fixed square-wave note sequence per playsound rising edge, starting the cycle after the request.
// Requests while busy are dropped, or restart the new sound at note 0 when SOUND_PREEMPT_EN is defined.
module sound_sequencer #(
  parameter int NOTE_LEN  = 1200000,
  parameter int GAP_LEN   = 120000,
  parameter int TONE_UNIT = 1000
) (
  input logic              clk,
  input logic              reset,
  sound_sequencer_if.slave bus
);
  localparam int MAX_DUR = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int DUR_W   = $clog2(MAX_DUR + 1);
  localparam int HP_W    = $clog2(TONE_UNIT * 64 + 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t           state_q, state_d;
  logic             play_q;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       idx_q, idx_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             spk_q, spk_d;
  logic             done_q, done_d;
  logic             req;
  logic             last_note;
  logic [6:0]       code;
  logic [HP_W-1:0]  half_per;

  function automatic logic [6:0] note_code(input logic [1:0] sel, input logic [1:0] idx);
    logic [6:0] c;
    c = 7'd24;
    case (sel)
      2'd1: begin
        case (idx)
          2'd0:    c = 7'd24;
          2'd1:    c = 7'd20;
          default: c = 7'd16;
        endcase
      end
      2'd2: begin
        case (idx)
          2'd0:    c = 7'd40;
          2'd1:    c = 7'd48;
          2'd2:    c = 7'd56;
          default: c = 7'd64;
        endcase
      end
      2'd3: begin
        case (idx)
          2'd0:    c = 7'd24;
          2'd1:    c = 7'd20;
          2'd2:    c = 7'd16;
          default: c = 7'd12;
        endcase
      end
      default: c = 7'd24;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] sel);
    logic [1:0] l;
    case (sel)
      2'd0:    l = 2'd0;
      2'd1:    l = 2'd2;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

  assign req       = bus.playsound & ~play_q;
  assign code      = note_code(sel_q, idx_q);
  assign half_per  = HP_W'(TONE_UNIT) * HP_W'(code);
  assign last_note = (idx_q == last_idx(sel_q));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    hp_d    = hp_q;
    spk_d   = spk_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = TONE;
          sel_d   = bus.soundselector;
          idx_d   = '0;
          dur_d   = '0;
          hp_d    = '0;
          spk_d   = 1'b0;
        end
      end
      TONE: begin
        dur_d = dur_q + DUR_W'(1);
        if (hp_q == half_per - HP_W'(1)) begin
          hp_d  = '0;
          spk_d = ~spk_q;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
        // End of note overrides any toggle landing on the same cycle.
        if (dur_q == DUR_W'(NOTE_LEN - 1)) begin
          dur_d = '0;
          hp_d  = '0;
          spk_d = 1'b0;
          if (last_note) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        dur_d = dur_q + DUR_W'(1);
        if (dur_q == DUR_W'(GAP_LEN - 1)) begin
          dur_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = TONE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SOUND_PREEMPT_EN
    if (req && (state_q != IDLE)) begin
      state_d = TONE;
      sel_d   = bus.soundselector;
      idx_d   = '0;
      dur_d   = '0;
      hp_d    = '0;
      spk_d   = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      play_q  <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      dur_q   <= '0;
      hp_q    <= '0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      play_q  <= bus.playsound;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      hp_q    <= hp_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
    end
  end

  assign bus.speaker  = spk_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: an event scoreboard of expected speaker/busy/note_idx/done changes per cycle.
module tb_sound_sequencer;
  localparam int NOTE_LEN  = 100;
  localparam int GAP_LEN   = 4;
  localparam int TONE_UNIT = 1;
  localparam int K_SPK  = 0;
  localparam int K_BUSY = 1;
  localparam int K_IDX  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  sound_sequencer_if bus ();

  sound_sequencer #(.NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN), .TONE_UNIT(TONE_UNIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ev_t  q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   a_spk = 0, a_busy = 0, a_idx = 0;
  int   m_spk = 0, m_busy = 0, m_idx = 0;
  logic s_spk, s_busy, s_done;
  logic [1:0] s_idx;
  logic p_spk = 1'b0, p_busy = 1'b0;
  logic [1:0] p_idx = 2'd0;

  function automatic int code_of(input int sel, input int n);
    case (sel)
      0:       return 24;
      1:       return 24 - 4 * n;
      2:       return 40 + 8 * n;
      default: return 24 - 4 * n;
    endcase
  endfunction

  function automatic int notes_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 3 : 4;
  endfunction

  function automatic void push(input int k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    q.push_back(e);
  endfunction

  // Expected state after every queued event, starting from the last consumed one.
  function automatic void rebuild();
    m_spk  = a_spk;
    m_busy = a_busy;
    m_idx  = a_idx;
    foreach (q[i]) begin
      case (q[i].kind)
        K_SPK:   m_spk  = int'(q[i].val);
        K_BUSY:  m_busy = int'(q[i].val);
        K_IDX:   m_idx  = int'(q[i].val);
        default: ;
      endcase
    end
  endfunction

  function automatic void flush_from(input int c);
    ev_t keep[$];
    foreach (q[i]) if (q[i].cyc < c) keep.push_back(q[i]);
    q = keep;
  endfunction

  task automatic push_sound(input int sel, input int e);
    int s;
    int h;
    int spk;
    flush_from(e);
    rebuild();
    if (m_spk != 0) push(K_SPK, e, 0);
    if (m_busy == 0) push(K_BUSY, e, 1);
    if (m_idx != 0) push(K_IDX, e, 0);
    s = e;
    for (int n = 0; n < notes_of(sel); n++) begin
      if (n > 0) push(K_IDX, s, n);
      h   = code_of(sel, n) * TONE_UNIT;
      spk = 0;
      for (int t = h; t < NOTE_LEN; t += h) begin
        spk = 1 - spk;
        push(K_SPK, s + t, spk);
      end
      if (spk != 0) push(K_SPK, s + NOTE_LEN, 0);
      if (n == notes_of(sel) - 1) begin
        push(K_BUSY, s + NOTE_LEN, 0);
        push(K_DONE, s + NOTE_LEN, 1);
      end else begin
        s = s + NOTE_LEN + GAP_LEN;
      end
    end
    rebuild();
  endtask

  task automatic check(input int k, input logic [31:0] v);
    ev_t e;
    total++;
    assert (q.size() > 0) else begin
      bad++;
      $error("FAIL unexpected_event kind=%0d cyc=%0d val=%0h, expected no event", k, cyc, v);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      assert (k === e.kind && cyc === e.cyc && v === e.val) else begin
        bad++;
        $error("FAIL event got kind=%0d cyc=%0d val=%0h, want kind=%0d cyc=%0d val=%0h",
               k, cyc, v, e.kind, e.cyc, e.val);
      end
      case (e.kind)
        K_SPK:   a_spk  = int'(e.val);
        K_BUSY:  a_busy = int'(e.val);
        K_IDX:   a_idx  = int'(e.val);
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    s_spk  = bus.speaker;
    s_busy = bus.busy;
    s_idx  = bus.note_idx;
    s_done = bus.done;
    if (s_spk !== p_spk) check(K_SPK, {31'd0, s_spk});
    if (s_busy !== p_busy) check(K_BUSY, {31'd0, s_busy});
    if (s_idx !== p_idx) check(K_IDX, {30'd0, s_idx});
    if (s_done !== 1'b0) check(K_DONE, {31'd0, s_done});
    p_spk  = s_spk;
    p_busy = s_busy;
    p_idx  = s_idx;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_play(input int sel);
    bus.soundselector = sel[1:0];
    bus.playsound     = 1'b1;
    tick();
    bus.playsound     = 1'b0;
  endtask

  task automatic end_check(input string tag);
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL %s pending_events=%0d want 0 (first pending cyc=%0d)", tag, q.size(), q[0].cyc);
    end
  endtask

  task automatic out_check(input string tag);
    total++;
    assert (bus.speaker === 1'b0) else begin bad++; $error("FAIL %s speaker=%b want 0", tag, bus.speaker); end
    total++;
    assert (bus.busy === 1'b0) else begin bad++; $error("FAIL %s busy=%b want 0", tag, bus.busy); end
    total++;
    assert (bus.done === 1'b0) else begin bad++; $error("FAIL %s done=%b want 0", tag, bus.done); end
    total++;
    assert (bus.note_idx === 2'd0) else begin bad++; $error("FAIL %s note_idx=%0d want 0", tag, bus.note_idx); end
  endtask

  initial begin
    int e;
    int e2;
    reset             = 1'b0;
    bus.playsound     = 1'b0;
    bus.soundselector = 2'd0;
    tick();
    tick();
    out_check("reset_state");
    reset = 1'b1;
    tick();
    tick();

    // UI_PRESS: one 24-cycle half-period note, done at entry+100.
    e = cyc + 1;
    push_sound(0, e);
    pulse_play(0);
    run_to(e + 110);
    end_check("ui_press");

    // NEXTLEVEL: three notes separated by 4-cycle silent gaps.
    e = cyc + 1;
    push_sound(1, e);
    pulse_play(1);
    run_to(e + 320);
    end_check("nextlevel");

    // CRASH with the selector changed mid-sound; the latched selection must hold.
    e = cyc + 1;
    push_sound(2, e);
    pulse_play(2);
    run_to(e + 200);
    bus.soundselector = 2'd3;
    run_to(e + 420);
    end_check("crash_latched");

    // Second rising edge at cycle 50 of UI_PRESS selecting CRASH.
    e = cyc + 1;
    push_sound(0, e);
    pulse_play(0);
    run_to(e + 49);
    e2 = cyc + 1;
`ifdef SOUND_PREEMPT_EN
    push_sound(2, e2);
`endif
    pulse_play(2);
    run_to(e2 + 430);
    end_check("busy_request");

    // Holding playsound high must not retrigger.
    e = cyc + 1;
    push_sound(0, e);
    bus.soundselector = 2'd0;
    bus.playsound     = 1'b1;
    run_to(e + 150);
    bus.playsound = 1'b0;
    tick();
    end_check("hold_high");

    // Request on the first IDLE cycle is accepted while done pulses.
    e = cyc + 1;
    push_sound(0, e);
    pulse_play(0);
    run_to(e + NOTE_LEN);
    total++;
    assert (bus.done === 1'b1) else begin bad++; $error("FAIL b2b_done done=%b want 1", bus.done); end
    e2 = cyc + 1;
    push_sound(1, e2);
    pulse_play(1);
    run_to(e2 + 320);
    end_check("back_to_back");

    // Reset at cycle 150 of CELEBRATION, then playsound held high across release.
    e = cyc + 1;
    push_sound(3, e);
    pulse_play(3);
    run_to(e + 149);
    total++;
    assert (bus.busy === 1'b1 && bus.note_idx === 2'd1) else begin
      bad++;
      $error("FAIL pre_reset busy=%b note_idx=%0d want busy=1 note_idx=1", bus.busy, bus.note_idx);
    end
    reset = 1'b0;
    #1;
    out_check("reset_mid");
    q.delete();
    a_spk  = 0;
    a_busy = 0;
    a_idx  = 0;
    p_spk  = 1'b0;
    p_busy = 1'b0;
    p_idx  = 2'd0;
    bus.soundselector = 2'd1;
    bus.playsound     = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    e = cyc + 1;
    push_sound(1, e);
    run_to(e + 320);
    bus.playsound = 1'b0;
    tick();
    end_check("reset_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter NOTE_LEN, default 1200000: clk cycles per note.
REQ-002 SHALL have parameter GAP_LEN, default 120000: clk cycles of silence between notes.
REQ-003 SHALL have parameter TONE_UNIT, default 1000: clk cycles per half-period code unit.
REQ-004 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-005 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: soundselector  input  2  0=UI_PRESS, 1=NEXTLEVEL, 2=CRASH, 3=CELEBRATION, from the game-state block.
REQ-007 SHALL have ports: playsound  input  1  request from the game-state block; acted on at its rising edge.
REQ-008 SHALL have ports: speaker  output  1  square-wave drive to the piezo/amp.
REQ-009 SHALL have ports: busy  output  1  high while a sound is in progress.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse when a sound completes.
REQ-011 SHALL have ports: note_idx  output  2  index of the current note.

Function
REQ-012 SHALL register playsound each cycle; a request is a cycle where playsound=1 and the previous sample=0.
REQ-013 SHALL latch soundselector on the request cycle; later changes SHALL NOT affect the running sound.
REQ-014 SHALL implement states IDLE, TONE, GAP.
REQ-015 IDLE + request SHALL go to TONE next cycle with note_idx=0, busy=1, speaker=0, counters cleared.
REQ-016 Note tables (half-period codes): UI_PRESS {24}; NEXTLEVEL {24,20,16}; CRASH {40,48,56,64}; CELEBRATION {24,20,16,12}.
REQ-017 In TONE, speaker SHALL toggle every TONE_UNIT*code cycles, with the first toggle TONE_UNIT*code cycles after TONE entry.
REQ-018 TONE SHALL last exactly NOTE_LEN cycles.
REQ-019 After a non-final note, the block SHALL enter GAP for exactly GAP_LEN cycles with speaker=0, then enter TONE with note_idx+1 and speaker=0.
REQ-020 After the final note, the block SHALL return to IDLE, set speaker=0 and busy=0, and pulse done=1 for exactly that first IDLE cycle.
REQ-021 Half-period and duration counters SHALL be wide enough for TONE_UNIT*64 and max(NOTE_LEN, GAP_LEN) without wrap.
REQ-022 Holding playsound high SHALL NOT retrigger; a new rising edge is required.
REQ-023 A request arriving on the same cycle the block returns to IDLE SHALL be accepted, with done still pulsing.
REQ-024 A request while busy SHALL be handled per the Configuration requirements.

Reset
REQ-025 Reset low SHALL immediately force: state=IDLE, speaker=0, busy=0, done=0, note_idx=0, counters=0, previous-playsound sample=0.
REQ-026 Reset mid-sound SHALL abort silently, with no done pulse.
REQ-027 After reset release, playsound already high SHALL count as a rising edge on the first clk edge.

Configuration
REQ-028 Macro SOUND_PREEMPT_EN, when defined: a request while busy SHALL restart at note 0 of the newly latched sound next cycle, with speaker=0 and no done pulse for the aborted sound.
REQ-029 Without SOUND_PREEMPT_EN: requests while busy SHALL be ignored and discarded, not queued.

Verification (NOTE_LEN=100, GAP_LEN=4, TONE_UNIT=1)
REQ-030 UI_PRESS request: busy high for 100 cycles; speaker toggles at entry+24/48/72/96; done pulses once at cycle 100; speaker=0 afterward.
REQ-031 NEXTLEVEL request: busy high for 308 cycles; note_idx 0->1->2; half-periods 24/20/16; speaker=0 during both 4-cycle gaps.
REQ-032 CRASH request, with soundselector changed to 3 mid-sound: CRASH tones (40..64) play to completion; busy for 412 cycles.
REQ-033 Second rising edge of playsound at cycle 50 of UI_PRESS, selector=2: with SOUND_PREEMPT_EN, CRASH starts next cycle with no done at cycle 100; without it, ignored and done at cycle 100.
REQ-034 Reset asserted at cycle 150 of CELEBRATION: all outputs 0 immediately; no done pulse; playsound held high across release starts a new sound on the first clk edge.
